cmd_sequencer: RTL

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_seq_if.sv | 34 +++
 rtl/cmd_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cmd_seq_if.sv
// Command sequencer bus: host-side queue controls, sender handshake and status.
interface cmd_seq_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          wr_cmd;
  logic [15:0]   wr_data;
  logic          start;
  logic          abort;
  logic [15:0]   cmd;
  logic          snd_cmd;
  logic          cmd_snt;
  logic          resp_rdy;
  logic [7:0]    resp;
  logic          busy;
  logic          done;
  logic          err;
  logic          full;
  logic          empty;
  logic [CW-1:0] cnt;

  // Environment side: host, UART sender and response path
  modport master (
    output wr_cmd, wr_data, start, abort, cmd_snt, resp_rdy, resp,
    input  cmd, snd_cmd, busy, done, err, full, empty, cnt
  );

  // Sequencer side
  modport slave (
    input  wr_cmd, wr_data, start, abort, cmd_snt, resp_rdy, resp,
    output cmd, snd_cmd, busy, done, err, full, empty, cnt
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Queues 16-bit robot commands and issues them one at a time, waiting for
// the sender to finish and for a positive acknowledge before popping.
module cmd_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [23:0] TMO_CLKS = 24'd8_000_000,
  parameter logic [7:0]  POS_ACK  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  cmd_seq_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_SNT  = 3'd2,
    WAIT_RESP = 3'd3,
    ERR       = 3'd4
  } state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [23:0]   tmo;
  logic          push_c;
  logic          pop_c;
  logic [CW-1:0] cnt_nxt;

  // Push/pop qualification and next occupancy; abort discards everything
  always_comb begin
    push_c  = 1'b0;
    pop_c   = 1'b0;
    cnt_nxt = bus.cnt;
    if (bus.abort) begin
      cnt_nxt = '0;
    end else begin
      push_c  = bus.wr_cmd && !bus.full;
      pop_c   = (state == WAIT_RESP) && bus.resp_rdy && (bus.resp == POS_ACK);
      cnt_nxt = bus.cnt + CW'(push_c) - CW'(pop_c);
    end
  end

  // Circular pointers and registered occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      bus.cnt   <= '0;
      bus.full  <= 1'b0;
      bus.empty <= 1'b1;
    end else begin
      if (bus.abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + AW'(1);
        if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      end
      bus.cnt   <= cnt_nxt;
      bus.full  <= (cnt_nxt == CW'(DEPTH));
      bus.empty <= (cnt_nxt == '0);
    end
  end

  // Command storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.wr_data;
  end

  // Sequencing FSM with registered outputs and response timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo         <= '0;
      bus.cmd     <= 16'h0000;
      bus.snd_cmd <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.snd_cmd <= 1'b0;
      bus.done    <= 1'b0;
      if (bus.abort) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
        bus.err  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.empty) begin
              state    <= SEND;
              bus.busy <= 1'b1;
            end
          end
          SEND: begin
            bus.cmd     <= mem[rd_ptr];
            bus.snd_cmd <= 1'b1;
            state       <= WAIT_SNT;
          end
          WAIT_SNT: begin
            if (bus.cmd_snt) begin
              state <= WAIT_RESP;
              tmo   <= '0;
            end
          end
          WAIT_RESP: begin
            if (bus.resp_rdy) begin
              if (bus.resp == POS_ACK) begin
                if (cnt_nxt != '0) begin
                  state <= SEND;
                end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                end
              end else begin
                state    <= ERR;
                bus.busy <= 1'b0;
                bus.err  <= 1'b1;
              end
            end else if (tmo == TMO_CLKS - 24'd1) begin
              state    <= ERR;
              bus.busy <= 1'b0;
              bus.err  <= 1'b1;
            end else if (tmo != '1) begin
              tmo <= tmo + 24'd1;
            end
          end
          ERR: begin
            if (bus.start) begin
              state    <= SEND;
              bus.busy <= 1'b1;
              bus.err  <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.err  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
